alu_share_arbiter: RTL
======================

# alu_share_arbiter

Shares the single combinational ALU between two requesters (e.g. the integer pipe and the address/branch unit) with a valid/ready request channel and a valid/ready response channel per requester. It picks one request with round-robin priority, registers its operands, drives the ALU for one execute cycle, then captures the result and the four flags. It holds the response until the owning requester accepts it. Only one operation is in flight at a time.

## Interface
- DATA_W, 32, operand/result width (the ALU is fixed at 32)
- FUNC_W, 6, function-code width
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accept
- req_a0, req_b0 / req_a1, req_b1  in  DATA_W each  operands for requester 0 / 1
- req_func0 / req_func1  in  FUNC_W  ALU function code for requester 0 / 1
- req_cin  in  2  carry-in per requester
- resp_valid  out  2  per-requester response valid
- resp_ready  in  2  per-requester response accept
- resp_out  out  DATA_W  result, shared and qualified by resp_valid
- resp_flags  out  4  {N,Z,C,V}, shared
- resp_err  out  1  illegal function code (see Configuration)
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_func  out  FUNC_W  ALU function select
- alu_cin  out  1  ALU carry-in
- alu_out  in  DATA_W  ALU result
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags

## Operation
- FSM with three states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the highest-priority requester with valid set; req_ready[grant] = 1 and the other bit = 0. With no valid request, req_ready = 0.
  - When req_valid and req_ready are both high, latch A, B, func and cin into the operand registers, record the owner, and go to EXEC.
- EXEC: alu_* outputs come from the operand registers. At the end of the cycle, capture alu_out and {alu_n,alu_z,alu_c,alu_v} into the response registers, then go to RESP.
- RESP:
  - resp_valid[owner] = 1 and resp_valid for the other requester = 0.
  - When resp_ready[owner] is also high, go to IDLE and set the priority pointer to the non-owner.
  - The FSM waits in RESP indefinitely under backpressure. Nothing else is accepted while waiting.
- Round-robin: a 1-bit priority pointer, reset 0, so requester 0 wins a tie after reset. The pointer updates only on response completion. When both requesters are valid back to back, grants alternate strictly.
- alu_* outputs always reflect the operand registers; they hold their value outside EXEC. The ALU is combinational, so EXEC samples settled values.
- A requester may drop req_valid before it is granted; that costs nothing. Once a request is accepted it cannot be withdrawn.
- Widths: results and flags pass through unmodified. The arbiter does no arithmetic.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE and the pointer to 0.
  - req_ready = 0, resp_valid = 0, resp_out = 0, resp_flags = 0, resp_err = 0.
  - alu_a = alu_b = 0, alu_func = 0, alu_cin = 0.
- Reset asserted mid-operation aborts the operation with no response; the requester must reissue.
- Latency: request accepted at edge N gives resp_valid high from edge N+2. The earliest next accept is at edge N+3 (resp_ready high at N+2).
- Peak throughput: one operation per 3 cycles.
- resp_out, resp_flags and resp_err are stable for the whole time resp_valid is high.

## Configuration
- ALU_ARB_FUNC_CHECK_EN defined:
  - On accept, func is checked against the legal set 100000, 100001, 001000, 000101, 100010, 100011, 011001, 101010, 101011, 001010, 001011, 100100, 001100, 100101, 001101, 100110, 001110, 100111, 001111, 000000, 000100, 000011, 000111, 000010, 000110.
  - An illegal code skips EXEC (IDLE goes straight to RESP) and responds with resp_out = 0, flags = 0, resp_err = 1. Latency is 1 cycle.
- Not defined: every code is forwarded to the ALU, and resp_err is tied to 0.

## Structure
- Package alu_arb_pkg holds:
  - the state enum {IDLE, EXEC, RESP};
  - localparams for every function code;
  - the legal-code function;
  - flag bit indices (N=3, Z=2, C=1, V=0).
- Sub-module alu_rr_arb: a 2-way round-robin picker. Inputs are valid[1:0] and the pointer; output is a one-hot grant. It is purely combinational, and the pointer register lives in the parent.

## Test plan
- Reset: hold rst_n low mid-EXEC -> all outputs 0 immediately; after release, no resp_valid is produced.
- Requester 0 only, A=0x80000000, B=0x80000002, func=100000 -> resp_valid[0] at accept+2, resp_out=0x00000002, flags N=0, Z=0, C=1, V=1.
- Both valid continuously, func=100100 -> grant order 0,1,0,1; each response goes only to its owner; accepts are 3 cycles apart.
- Backpressure: resp_ready[1]=0 for 5 cycles -> resp_valid[1] and resp_out are held, req_ready stays 0, and the pending request 0 is granted on the cycle after the response completes.
- ALU_ARB_FUNC_CHECK_EN build, func=111111 -> resp_valid at accept+1, resp_err=1, resp_out=0, no EXEC cycle. Without the macro, resp_err stays 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared definitions for the ALU share arbiter:
//   - arb_state_t     : arbiter FSM states (IDLE, EXEC, RESP)
//   - FLAG_*          : bit positions of {N,Z,C,V} in the flag vector
//   - FN_*            : every function code the shared ALU implements
//   - func_is_legal() : membership test against the FN_* set
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_ADDI  = 6'b001000;
  localparam logic [5:0] FN_BNE   = 6'b000101;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_PASSB = 6'b011001;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLTI  = 6'b001010;
  localparam logic [5:0] FN_SLTIU = 6'b001011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_ANDI  = 6'b001100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ORI   = 6'b001101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_XORI  = 6'b001110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_LUI   = 6'b001111;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRLV  = 6'b000110;

  function automatic logic func_is_legal(input logic [5:0] func);
    case (func)
      FN_ADD, FN_ADDU, FN_ADDI, FN_BNE, FN_SUB, FN_SUBU, FN_PASSB,
      FN_SLT, FN_SLTU, FN_SLTI, FN_SLTIU, FN_AND, FN_ANDI, FN_OR,
      FN_ORI, FN_XOR, FN_XORI, FN_NOR, FN_LUI, FN_SLL, FN_SLLV,
      FN_SRA, FN_SRAV, FN_SRL, FN_SRLV: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb
// Two-way round-robin picker, purely combinational. The requester named
// by ptr wins a tie; otherwise whichever requester is valid wins.
// Ports:
//   valid[1:0] : request valids (bit i = requester i)
//   ptr        : priority pointer (owned by the parent)
//   grant[1:0] : one-hot grant, all-zero when nothing is valid
module alu_rr_arb (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default first so every path assigns grant and no latch is inferred.
    grant = 2'b00;
    if (ptr == 1'b0) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      if (valid[1])      grant = 2'b10;
      else if (valid[0]) grant = 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters. One operation is in
// flight at a time: IDLE picks a request round-robin and registers its
// operands, EXEC drives the ALU for one cycle and captures result + flags,
// RESP holds the response until the owner accepts it.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]   : request handshake per requester
//   req_a0/b0/func0, req_a1/b1/func1, req_cin[1:0] : request payloads
//   resp_valid/resp_ready[1:0] : response handshake per requester
//   resp_out, resp_flags{N,Z,C,V}, resp_err : shared response payload
//   alu_a/b/func/cin           : operands to the shared ALU (registered)
//   alu_out, alu_n/z/c/v       : ALU result and flags
// Configuration:
//   ALU_ARB_FUNC_CHECK_EN : when defined, illegal function codes bypass EXEC
//   and answer one cycle after accept with resp_err=1 and a zero result.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [FUNC_W-1:0] req_func0,
  input  logic [FUNC_W-1:0] req_func1,
  input  logic [1:0]        req_cin,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_out,
  output logic [3:0]        resp_flags,
  output logic              resp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v
);

  arb_state_t        state;
  logic              ptr;
  logic              owner;
  logic [DATA_W-1:0] op_a, op_b;
  logic [FUNC_W-1:0] op_func;
  logic              op_cin;
  logic [DATA_W-1:0] res_out;
  logic [3:0]        res_flags;

  logic [1:0]        grant;
  logic              sel;
  logic              accept;
  logic              func_ok;
  logic [DATA_W-1:0] sel_a, sel_b;
  logic [FUNC_W-1:0] sel_func;
  logic              sel_cin;

  alu_rr_arb u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Ready is only offered while idle, and only to the granted requester.
  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);

  assign sel      = grant[1];
  assign sel_a    = sel ? req_a1    : req_a0;
  assign sel_b    = sel ? req_b1    : req_b0;
  assign sel_func = sel ? req_func1 : req_func0;
  assign sel_cin  = req_cin[sel];

`ifdef ALU_ARB_FUNC_CHECK_EN
  logic err_q;

  assign func_ok = func_is_legal(sel_func);

  // Error flag is decided at accept and held unchanged through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_q <= 1'b0;
    else if (state == IDLE && accept)   err_q <= ~func_ok;
  end

  assign resp_err = err_q;
`else
  assign func_ok  = 1'b1;
  assign resp_err = 1'b0;
`endif

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_func   <= '0;
      op_cin    <= 1'b0;
      res_out   <= '0;
      res_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= sel;
            if (func_ok) begin
              op_a    <= sel_a;
              op_b    <= sel_b;
              op_func <= sel_func;
              op_cin  <= sel_cin;
              state   <= EXEC;
            end else begin
              // Illegal code: answer directly, ALU operands untouched.
              res_out   <= '0;
              res_flags <= '0;
              state     <= RESP;
            end
          end
        end
        EXEC: begin
          res_out           <= alu_out;
          res_flags[FLAG_N] <= alu_n;
          res_flags[FLAG_Z] <= alu_z;
          res_flags[FLAG_C] <= alu_c;
          res_flags[FLAG_V] <= alu_v;
          state             <= RESP;
        end
        RESP: begin
          // Pointer moves only on completion, handing priority to the other side.
          if (resp_ready[owner]) begin
            ptr   <= ~owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_out   = res_out;
  assign resp_flags = res_flags;

  assign alu_a    = op_a;
  assign alu_b    = op_b;
  assign alu_func = op_func;
  assign alu_cin  = op_cin;

endmodule
